// File: rtl/minterm_scan_ctrl.sv
// Minterm scan controller: walks a 4-input decoder tree through all 16 minterms,
// samples F for each one into a truth table and compares it with an expected table.
// The expected/captured tables are exposed as expect_i / table_o because "expect"
// and "table" are reserved words in SystemVerilog.
module minterm_scan_ctrl #(
  parameter int unsigned SETTLE = 1  // extra wait cycles (0..15) between drive and sample
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expect_i,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        EN,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_o,
  output logic        mismatch,
  output logic [3:0]  err_idx
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  localparam bit         HasSettle  = (SETTLE > 0);
  localparam logic [3:0] SettleLast = HasSettle ? 4'(SETTLE - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tbl_q, tbl_d;
  logic        mis_q, mis_d;
  logic [3:0]  err_q, err_d;
  logic [15:0] diff;
  logic        scan;

  // Lowest set bit position of v, 0 when v is zero.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'd0;
      tbl_q   <= 16'd0;
      mis_q   <= 1'b0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: sequencing, table capture and final compare.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mis_d   = mis_q;
    err_d   = err_q;
    diff    = 16'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          exp_d   = expect_i;
          tbl_d   = 16'd0;
          mis_d   = 1'b0;
          err_d   = 4'd0;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      StDrive: begin
        if (abort) begin
          state_d = StIdle;
          mis_d   = 1'b0;
          err_d   = 4'd0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = 4'd0;
          state_d = HasSettle ? StSettle : StSample;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          mis_d   = 1'b0;
          err_d   = 4'd0;
          cnt_d   = 4'd0;
        end else if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (abort) begin
          // Abort wins over the sample: this minterm is not written.
          state_d = StIdle;
          mis_d   = 1'b0;
          err_d   = 4'd0;
          cnt_d   = 4'd0;
        end else begin
          tbl_d[idx_q] = F;
          if (idx_q == 4'd15) begin
            // Compare includes the bit being written this cycle.
            diff    = tbl_d ^ exp_q;
            state_d = StDone;
            mis_d   = |diff;
            err_d   = lowest_set(diff);
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StDrive;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; minterm select is parked at 0 when not scanning.
  always_comb begin
    scan         = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
    busy         = scan;
    EN           = ~scan;
    done         = (state_q == StDone);
    {A, B, C, D} = scan ? idx_q : 4'd0;
    table_o      = tbl_q;
    mismatch     = mis_q;
    err_idx      = err_q;
  end

endmodule
